// File: rtl/cp0_exc_unit_pkg.sv
// cp0_exc_unit_pkg: CP0 register indices, bit positions, exception codes and
// packing helpers shared by the CP0 exception unit, its timer and the bench.
// Optional feature macro used elsewhere in this slice: CP0_TIMER_EN.
package cp0_exc_unit_pkg;

  // CP0 register indices (rd field of mfc0/mtc0)
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  // Bit positions inside SR and Cause
  localparam int SR_IE       = 0;
  localparam int SR_EXL      = 1;
  localparam int IM_LO       = 10;
  localparam int IP_LO       = 10;
  localparam int EXCCODE_LO  = 2;
  localparam int CAUSE_TI    = 30;
  localparam int CAUSE_BD    = 31;

  // Exception codes; an interrupt is recorded with code 0
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Assemble the architectural SR view from its stored fields
  function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl, input logic ie);
    logic [31:0] v;
    v = 32'd0;
    v[IM_LO +: 6] = im;
    v[SR_EXL]     = exl;
    v[SR_IE]      = ie;
    return v;
  endfunction

  // Assemble the architectural Cause view from its stored fields
  function automatic logic [31:0] pack_cause(input logic bd, input logic ti,
                                             input logic [5:0] ip, input logic [4:0] exc);
    logic [31:0] v;
    v = 32'd0;
    v[CAUSE_BD]           = bd;
    v[CAUSE_TI]           = ti;
    v[IP_LO +: 6]         = ip;
    v[EXCCODE_LO +: 5]    = exc;
    return v;
  endfunction

endpackage

// File: rtl/cp0_exc_unit_if.sv
// cp0_exc_unit_if: stage-M pipeline <-> CP0 signal bundle.
// master = pipeline side, slave = CP0 side. i_* flow into CP0, o_* flow out.
interface cp0_exc_unit_if #(
  parameter int NUM_IRQ = 6
);
  logic               i_we;
  logic [4:0]         i_addr;
  logic [31:0]        i_wdata;
  logic [31:0]        o_rdata;
  logic [31:0]        i_pc;
  logic               i_bd;
  logic [4:0]         i_excode;
  logic               i_eret;
  logic [NUM_IRQ-1:0] i_irq;
  logic               o_req;
  logic [31:0]        o_epc;

  modport master (
    output i_we, i_addr, i_wdata, i_pc, i_bd, i_excode, i_eret, i_irq,
    input  o_rdata, o_req, o_epc
  );

  modport slave (
    input  i_we, i_addr, i_wdata, i_pc, i_bd, i_excode, i_eret, i_irq,
    output o_rdata, o_req, o_epc
  );
endinterface

// File: rtl/cp0_exc_unit_timer.sv
// cp0_timer: Count/Compare pair with sticky timer-interrupt flag.
// Instantiated by cp0_exc_unit only when CP0_TIMER_EN is defined.
module cp0_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_we_count,
  input  logic        i_we_compare,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_ti
);
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;
  logic        w_match;

  assign w_match = (r_count == r_compare);

  // Count free-runs (a write replaces it); Compare write clears TI, else a match latches TI
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= 32'd0;
      r_compare <= 32'hFFFF_FFFF;
      r_ti      <= 1'b0;
    end else begin
      r_count <= i_we_count ? i_wdata : (r_count + 32'd1);
      if (i_we_compare) begin
        r_compare <= i_wdata;
        r_ti      <= 1'b0;
      end else if (w_match) begin
        r_ti <= 1'b1;
      end else begin
        r_ti <= r_ti;
      end
    end
  end

  // TI is visible in the very cycle Count reaches Compare, then held by r_ti
  assign o_ti      = r_ti | w_match;
  assign o_count   = r_count;
  assign o_compare = r_compare;
endmodule

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: stage-M coprocessor 0 holding SR/Cause/EPC/PRId, sampling
// NUM_IRQ level interrupt lines and raising a combinational flush request.
// Define CP0_TIMER_EN to add the Count/Compare timer (cp0_timer) whose TI
// flag is ORed into IP[15].
module cp0_exc_unit
  import cp0_exc_unit_pkg::*;
#(
  parameter int          NUM_IRQ = 6,
  parameter logic [31:0] PRID    = 32'h2021_0707
) (
  input logic            clk,
  input logic            rst_n,
  cp0_exc_unit_if.slave  bus
);
  logic [5:0]         r_im;
  logic               r_exl;
  logic               r_ie;
  logic               r_bd;
  logic [4:0]         r_exccode;
  logic [31:0]        r_epc;
  logic [NUM_IRQ-1:0] r_ip;

  logic [5:0]         w_ip;
  logic               w_ti;
  logic               w_int_req;
  logic               w_exc_req;
  logic               w_req;
  logic               w_wr_en;
  logic [31:0]        w_rdata;

`ifdef CP0_TIMER_EN
  logic [31:0] w_count;
  logic [31:0] w_compare;

  cp0_timer u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_we_count   (w_wr_en && (bus.i_addr == CP0_COUNT)),
    .i_we_compare (w_wr_en && (bus.i_addr == CP0_COMPARE)),
    .i_wdata      (bus.i_wdata),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_ti         (w_ti)
  );
`else
  assign w_ti = 1'b0;
`endif

  // Build the 6-bit IP field: implemented lines from the sampled irqs, TI folded into IP[15]
  always_comb begin
    w_ip = 6'd0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_ip[i] = r_ip[i];
    end
    w_ip[5] = w_ip[5] | w_ti;
  end

  assign w_int_req = r_ie & (|(w_ip & r_im));
  assign w_exc_req = (bus.i_excode != EXC_NONE);
  assign w_req     = ~r_exl & (w_int_req | w_exc_req);
  // mtc0 is suppressed in the cycle an exception is taken
  assign w_wr_en   = bus.i_we & ~w_req;

  // Exception entry, eret and mtc0 updates of SR/Cause/EPC; IP samples irq every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_im      <= 6'd0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_exccode <= 5'd0;
      r_epc     <= 32'd0;
      r_ip      <= '0;
    end else begin
      r_ip <= bus.i_irq;
      if (w_req) begin
        r_exl     <= 1'b1;
        r_bd      <= bus.i_bd;
        r_epc     <= bus.i_bd ? (bus.i_pc - 32'd4) : bus.i_pc;
        r_exccode <= w_int_req ? EXC_INT : bus.i_excode;
      end else begin
        if (bus.i_eret) begin
          r_exl <= 1'b0;
        end
        // an SR write in the same cycle as eret is applied after it, so it decides EXL
        if (w_wr_en && (bus.i_addr == CP0_SR)) begin
          r_im  <= bus.i_wdata[IM_LO +: 6];
          r_exl <= bus.i_wdata[SR_EXL];
          r_ie  <= bus.i_wdata[SR_IE];
        end
        if (w_wr_en && (bus.i_addr == CP0_EPC)) begin
          r_epc <= bus.i_wdata;
        end
      end
    end
  end

  // mfc0 read mux, combinational on addr; unlisted indices read zero
  always_comb begin
    w_rdata = 32'd0;
    case (bus.i_addr)
      CP0_SR:      w_rdata = pack_sr(r_im, r_exl, r_ie);
      CP0_CAUSE:   w_rdata = pack_cause(r_bd, w_ti, w_ip, r_exccode);
      CP0_EPC:     w_rdata = r_epc;
      CP0_PRID:    w_rdata = PRID;
`ifdef CP0_TIMER_EN
      CP0_COUNT:   w_rdata = w_count;
      CP0_COMPARE: w_rdata = w_compare;
`endif
      default:     w_rdata = 32'd0;
    endcase
  end

  assign bus.o_rdata = w_rdata;
  assign bus.o_req   = w_req;
  assign bus.o_epc   = r_epc;
endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb_cp0_exc_unit: directed scenarios for cp0_exc_unit followed by a random
// run checked against a behavioural CP0 model. Honours CP0_TIMER_EN.
module tb_cp0_exc_unit;
  import cp0_exc_unit_pkg::*;

  localparam int NUM_IRQ = 6;

  logic clk;
  logic rst_n;
  int   n_err;
  int   n_chk;

  cp0_exc_unit_if #(.NUM_IRQ(NUM_IRQ)) bus ();

  cp0_exc_unit #(.NUM_IRQ(NUM_IRQ), .PRID(32'h2021_0707)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [5:0]         m_im;
  logic               m_exl, m_ie, m_bd;
  logic [4:0]         m_exc;
  logic [31:0]        m_epc;
  logic [NUM_IRQ-1:0] m_irq_q;
  logic [31:0]        m_count, m_compare;
  logic               m_ti;

  task automatic model_reset();
    m_im = 6'd0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0; m_exc = 5'd0;
    m_epc = 32'd0; m_irq_q = '0; m_count = 32'd0; m_compare = 32'hFFFF_FFFF; m_ti = 1'b0;
  endtask

  function automatic logic m_ti_now();
`ifdef CP0_TIMER_EN
    return m_ti || (m_count == m_compare);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [5:0] m_ip();
    logic [5:0] v;
    v = 6'd0;
    for (int i = 0; i < NUM_IRQ; i++) v[i] = m_irq_q[i];
    if (m_ti_now()) v[5] = 1'b1;
    return v;
  endfunction

  function automatic logic m_int();
    return m_ie && ((m_ip() & m_im) != 6'd0);
  endfunction

  function automatic logic m_req();
    return !m_exl && (m_int() || (bus.i_excode != 5'd0));
  endfunction

  function automatic logic [31:0] m_rdata(input logic [4:0] a);
    case (a)
      5'd12: return (32'(m_im) << 10) + (32'(m_exl) << 1) + 32'(m_ie);
      5'd13: return (32'(m_bd) << 31) + (32'(m_ti_now()) << 30) + (32'(m_ip()) << 10) + (32'(m_exc) << 2);
      5'd14: return m_epc;
      5'd15: return 32'h2021_0707;
`ifdef CP0_TIMER_EN
      5'd9:  return m_count;
      5'd11: return m_compare;
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Apply the effect of one clock edge to the model, from the inputs now on the bus
  task automatic model_edge();
    logic req, intr, wr;
    intr = m_int();
    req  = m_req();
    wr   = bus.i_we && !req;
`ifdef CP0_TIMER_EN
    if (wr && bus.i_addr == 5'd11) begin
      m_compare = bus.i_wdata;
      m_ti = 1'b0;
    end else if (m_count == m_compare) begin
      m_ti = 1'b1;
    end
    m_count = (wr && bus.i_addr == 5'd9) ? bus.i_wdata : m_count + 32'd1;
`endif
    if (req) begin
      m_exl = 1'b1;
      m_bd  = bus.i_bd;
      m_epc = bus.i_bd ? bus.i_pc - 32'd4 : bus.i_pc;
      m_exc = intr ? 5'd0 : bus.i_excode;
    end else begin
      if (bus.i_eret) m_exl = 1'b0;
      if (wr && bus.i_addr == 5'd12) begin
        m_im = bus.i_wdata[15:10]; m_exl = bus.i_wdata[1]; m_ie = bus.i_wdata[0];
      end
      if (wr && bus.i_addr == 5'd14) m_epc = bus.i_wdata;
    end
    m_irq_q = bus.i_irq;
  endtask

  // ---------------- helpers ----------------
  task automatic tick();
    if (rst_n) model_edge(); else model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    bus.i_addr = a;
    #1;
    chk(tag, bus.o_rdata, exp);
  endtask

  task automatic idle();
    bus.i_we = 1'b0; bus.i_addr = 5'd0; bus.i_wdata = 32'd0; bus.i_pc = 32'd0;
    bus.i_bd = 1'b0; bus.i_excode = 5'd0; bus.i_eret = 1'b0; bus.i_irq = '0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.i_we = 1'b1; bus.i_addr = a; bus.i_wdata = d;
    tick();
    bus.i_we = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r32;
    logic [4:0]  ra;
    logic [4:0]  codes [4];
    codes[0] = EXC_ADEL; codes[1] = EXC_ADES; codes[2] = EXC_RI; codes[3] = EXC_OV;
    n_err = 0; n_chk = 0;
    rst_n = 1'b0;
    idle();
    model_reset();
    tick(); tick();

    // reset state
    chk("rst_req", {31'd0, bus.o_req}, 32'd0);
    chk_reg("rst_sr", CP0_SR, 32'd0);
    chk_reg("rst_cause", CP0_CAUSE, 32'd0);
    chk_reg("rst_epc", CP0_EPC, 32'd0);
    chk_reg("prid", CP0_PRID, 32'h2021_0707);
    rst_n = 1'b1;

    // interrupt on irq[0] with IE/IM[10]
    mtc0(CP0_SR, 32'h0000_0401);
    bus.i_irq = 6'b000001; bus.i_pc = 32'h3008; bus.i_bd = 1'b0;
    #1 chk("t2_req_n", {31'd0, bus.o_req}, 32'd0);
    tick();
    chk("t2_req_n1", {31'd0, bus.o_req}, 32'd1);
    tick();
    chk_reg("t2_cause", CP0_CAUSE, 32'h0000_0400);
    chk_reg("t2_epc", CP0_EPC, 32'h0000_3008);
    chk_reg("t2_sr", CP0_SR, 32'h0000_0403);
    chk("t2_epc_out", bus.o_epc, 32'h0000_3008);
    chk("t2_req_exl", {31'd0, bus.o_req}, 32'd0);

    // eret with irq still high, then a dropped mtc0 EPC during req
    bus.i_eret = 1'b1;
    tick();
    bus.i_eret = 1'b0;
    chk_reg("t5_sr", CP0_SR, 32'h0000_0401);
    chk("t5_req", {31'd0, bus.o_req}, 32'd1);
    bus.i_pc = 32'h3020;
    mtc0(CP0_EPC, 32'hDEAD_BEEC);
    chk_reg("t5_epc_drop", CP0_EPC, 32'h0000_3020);
    bus.i_irq = '0; bus.i_eret = 1'b1;
    tick();
    bus.i_eret = 1'b0;
    chk("t5_req_clear", {31'd0, bus.o_req}, 32'd0);

    // synchronous exception in a delay slot, then a masked one under EXL
    bus.i_excode = EXC_OV; bus.i_bd = 1'b1; bus.i_pc = 32'h3010;
    #1 chk("t3_req", {31'd0, bus.o_req}, 32'd1);
    tick();
    bus.i_excode = EXC_ADEL; bus.i_pc = 32'h3050; bus.i_bd = 1'b0;
    chk_reg("t3_epc", CP0_EPC, 32'h0000_300C);
    chk_reg("t3_cause", CP0_CAUSE, 32'h8000_0030);
    chk("t3_req_masked", {31'd0, bus.o_req}, 32'd0);
    tick();
    bus.i_excode = EXC_NONE;
    chk_reg("t3_epc_hold", CP0_EPC, 32'h0000_300C);
    chk_reg("t3_cause_hold", CP0_CAUSE, 32'h8000_0030);
    bus.i_eret = 1'b1;
    tick();
    bus.i_eret = 1'b0;

    // interrupt and exception together: interrupt wins
    bus.i_irq = 6'b000010;
    mtc0(CP0_SR, 32'h0000_0801);
    bus.i_excode = EXC_RI;
    #1 chk("t4_req", {31'd0, bus.o_req}, 32'd1);
    tick();
    bus.i_excode = EXC_NONE; bus.i_irq = '0;
    chk_reg("t4_cause", CP0_CAUSE, 32'h0000_0800);
    chk_reg("t4_sr", CP0_SR, 32'h0000_0803);
    bus.i_eret = 1'b1;
    tick();
    bus.i_eret = 1'b0;
    chk("t4_req_clear", {31'd0, bus.o_req}, 32'd0);

    // asynchronous reset while EXL=1
    bus.i_irq = 6'b000001;
    mtc0(CP0_SR, 32'h0000_0401);
    tick();
    chk_reg("t1_sr_exl", CP0_SR, 32'h0000_0403);
    rst_n = 1'b0;
    #1 chk("t1_req", {31'd0, bus.o_req}, 32'd0);
    chk_reg("t1_sr", CP0_SR, 32'd0);
    chk_reg("t1_cause", CP0_CAUSE, 32'd0);
    chk_reg("t1_epc", CP0_EPC, 32'd0);
`ifdef CP0_TIMER_EN
    chk_reg("t1_compare", CP0_COMPARE, 32'hFFFF_FFFF);
`endif
    model_reset();
    bus.i_irq = '0;
    tick();
    rst_n = 1'b1;

`ifdef CP0_TIMER_EN
    // timer interrupt at Count==Compare, cleared by a Compare write
    mtc0(CP0_COMPARE, 32'd5);
    mtc0(CP0_COUNT, 32'd0);
    mtc0(CP0_SR, 32'h0000_8001);
    chk_reg("t6_count1", CP0_COUNT, 32'd1);
    tick(); tick(); tick();
    chk("t6_req_early", {31'd0, bus.o_req}, 32'd0);
    tick();
    chk("t6_req", {31'd0, bus.o_req}, 32'd1);
    chk_reg("t6_count5", CP0_COUNT, 32'd5);
    chk_reg("t6_cause", CP0_CAUSE, 32'h4000_8000);
    tick();
    chk_reg("t6_cause_sticky", CP0_CAUSE, 32'h4000_8000);
    chk_reg("t6_sr", CP0_SR, 32'h0000_8003);
    mtc0(CP0_COMPARE, 32'h0000_0100);
    chk_reg("t6_cause_clr", CP0_CAUSE, 32'd0);
    chk_reg("t6_compare", CP0_COMPARE, 32'h0000_0100);
    bus.i_eret = 1'b1;
    tick();
    bus.i_eret = 1'b0;
`else
    mtc0(CP0_COUNT, 32'h0000_1234);
    mtc0(CP0_COMPARE, 32'h0000_0003);
    chk_reg("t6_count_none", CP0_COUNT, 32'd0);
    chk_reg("t6_compare_none", CP0_COMPARE, 32'd0);
    chk_reg("t6_cause_noti", CP0_CAUSE, m_rdata(CP0_CAUSE));
`endif

    // random traffic against the model
    for (int k = 0; k < 400; k++) begin
      r32 = $urandom;
      bus.i_irq    = r32[NUM_IRQ-1:0];
      bus.i_excode = ($urandom_range(0, 3) == 0) ? codes[$urandom_range(0, 3)] : 5'd0;
      bus.i_eret   = ($urandom_range(0, 7) == 0);
      bus.i_we     = ($urandom_range(0, 3) == 0);
      r32 = $urandom;
      case ($urandom_range(0, 6))
        0: ra = CP0_COUNT;
        1: ra = CP0_COMPARE;
        2: ra = CP0_SR;
        3: ra = CP0_CAUSE;
        4: ra = CP0_EPC;
        5: ra = CP0_PRID;
        default: ra = r32[4:0];
      endcase
      bus.i_addr  = ra;
      bus.i_wdata = $urandom;
      r32 = $urandom;
      bus.i_pc    = {r32[31:2], 2'b00};
      bus.i_bd    = r32[0];
      #1;
      chk("rnd_req", {31'd0, bus.o_req}, {31'd0, m_req()});
      chk("rnd_epc", bus.o_epc, m_epc);
      chk("rnd_rdata", bus.o_rdata, m_rdata(ra));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
